front_panel_cursor_ctrl: RTL and testbench

Sequences operator interaction with the Altair front-panel renderer. It takes level inputs from the keyboard or joystick and turns them into cursor movement over the 25 switch positions. It latches the state of the 17 toggle switches and issues one-cycle command pulses for the 8 on/off/on momentary switches. It also drives cursor_index_x, cursor_index_y and cursor_action into the renderer, which computes cursor_index = x + y.

---
 rtl/front_panel_pkg.sv | 57 +++++
 rtl/front_panel_cursor_ctrl_if.sv | 25 ++
 rtl/key_edge_repeat.sv | 26 ++
 rtl/front_panel_cursor_ctrl.sv | 124 ++++++++++++
 tb/tb_front_panel_cursor_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/front_panel_pkg.sv
// Shared types, constants and cursor-step arithmetic for the front-panel
// cursor controller and its key front end.
package front_panel_pkg;

  localparam int NUM_SWITCHES = 25;
  localparam int NUM_TOGGLE   = 17;
  localparam int NUM_MOM      = NUM_SWITCHES - NUM_TOGGLE;
  localparam int NUM_KEYS     = 6;

  localparam logic [4:0] ROW1_BASE    = 5'd16;
  localparam logic [3:0] ROW0_MAX_X   = 4'd15;
  localparam logic [3:0] ROW1_MAX_X   = 4'd8;
  localparam logic [4:0] TOGGLE_MAX_L = 5'd16;
  localparam logic [4:0] MOM_BASE_L   = 5'd17;

  typedef enum logic [1:0] {S_IDLE, S_REPEAT, S_HOLD} ctrl_state_t;

  // Enum value is both the bit index in the key vector and the priority rank
  // (lower value wins).
  typedef enum logic [2:0] {
    KEY_ACT_UP, KEY_ACT_DOWN, KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT
  } key_idx_t;

  typedef struct packed {
    logic [4:0] y;
    logic [3:0] x;
  } cursor_t;

  function automatic key_idx_t onehot_to_key(logic [NUM_KEYS-1:0] oh);
    key_idx_t k = KEY_ACT_UP;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (oh[i]) k = key_idx_t'(3'(i));
    end
    return k;
  endfunction

  // Wrap is an explicit compare against the row maximum, not 4-bit overflow.
  function automatic cursor_t step_cursor(key_idx_t dir, cursor_t c);
    cursor_t    n     = c;
    logic       row1  = (c.y == ROW1_BASE);
    logic [3:0] max_x = row1 ? ROW1_MAX_X : ROW0_MAX_X;
    case (dir)
      KEY_LEFT:  n.x = (c.x == 4'd0) ? max_x : c.x - 4'd1;
      KEY_RIGHT: n.x = (c.x >= max_x) ? 4'd0 : c.x + 4'd1;
      KEY_DOWN: begin
        if (!row1) begin
          n.y = ROW1_BASE;
          n.x = (c.x > ROW1_MAX_X) ? ROW1_MAX_X : c.x;
        end
      end
      KEY_UP: if (row1) n.y = 5'd0;
      default: ;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/front_panel_cursor_ctrl_if.sv
// Key inputs and renderer-facing outputs of the front-panel cursor controller.
interface front_panel_cursor_ctrl_if;
  logic        key_up;
  logic        key_down;
  logic        key_left;
  logic        key_right;
  logic        key_act_up;
  logic        key_act_down;
  logic [3:0]  cursor_index_x;
  logic [4:0]  cursor_index_y;
  logic        cursor_action;
  logic [16:0] sw_state;
  logic [7:0]  mom_up;
  logic [7:0]  mom_down;

  modport master (
    output key_up, key_down, key_left, key_right, key_act_up, key_act_down,
    input  cursor_index_x, cursor_index_y, cursor_action, sw_state, mom_up, mom_down
  );

  modport slave (
    input  key_up, key_down, key_left, key_right, key_act_up, key_act_down,
    output cursor_index_x, cursor_index_y, cursor_action, sw_state, mom_up, mom_down
  );
endinterface

// File: rtl/key_edge_repeat.sv
// Per-key rising-edge detection and priority select of a single one-hot event
// per cycle; lower key index has higher priority.
module key_edge_repeat
  import front_panel_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] evt_oh
);

  logic [NUM_KEYS-1:0] prev_q;
  logic [NUM_KEYS-1:0] edges;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= keys;
  end

  // Edges that lose arbitration are dropped, not queued.
  assign edges  = keys & ~prev_q;
  assign evt_oh = edges & (~edges + {{(NUM_KEYS-1){1'b0}}, 1'b1});

endmodule

// File: rtl/front_panel_cursor_ctrl.sv
// Front-panel cursor controller: key events to cursor moves with auto-repeat,
// toggle-switch latching and momentary-switch pulses with a visual hold.
module front_panel_cursor_ctrl
  import front_panel_pkg::*;
#(
  parameter int REPEAT_DELAY  = 12000000,
  parameter int REPEAT_PERIOD = 3000000,
  parameter int HOLD_CYCLES   = 6000000,
  parameter int CNT_W         = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  front_panel_cursor_ctrl_if.slave  bus
);

  logic [NUM_KEYS-1:0]   keys, evt_oh;
  ctrl_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  key_idx_t              rep_q, rep_d, evt_key;
  cursor_t               cur_q, cur_d;
  logic [NUM_TOGGLE-1:0] sw_q, sw_d, sw_mask;
  logic [NUM_MOM-1:0]    mom_up_q, mom_up_d, mom_dn_q, mom_dn_d, mom_oh;
  logic                  act_q, act_d;
  logic [4:0]            lin;

  assign keys = {bus.key_right, bus.key_left, bus.key_down,
                 bus.key_up, bus.key_act_down, bus.key_act_up};

  key_edge_repeat u_key_edge_repeat (
    .clk    (clk),
    .reset  (reset),
    .keys   (keys),
    .evt_oh (evt_oh)
  );

  assign evt_key = onehot_to_key(evt_oh);
  assign lin     = {1'b0, cur_q.x} + cur_q.y;
  assign sw_mask = NUM_TOGGLE'(1) << lin;
  assign mom_oh  = NUM_MOM'(1) << 3'(lin - MOM_BASE_L);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    cur_d    = cur_q;
    sw_d     = sw_q;
    mom_up_d = '0;
    mom_dn_d = '0;
    act_d    = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          act_d = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_IDLE, S_REPEAT: begin
        if (|evt_oh) begin
          if (evt_key == KEY_ACT_UP || evt_key == KEY_ACT_DOWN) begin
            act_d = 1'b1;
            if (lin <= TOGGLE_MAX_L) begin
              sw_d    = (evt_key == KEY_ACT_UP) ? (sw_q | sw_mask) : (sw_q & ~sw_mask);
              state_d = S_IDLE;
            end else begin
              if (evt_key == KEY_ACT_UP) mom_up_d = mom_oh;
              else                       mom_dn_d = mom_oh;
              cnt_d   = CNT_W'(HOLD_CYCLES - 1);
              state_d = S_HOLD;
            end
          end else begin
            cur_d   = step_cursor(evt_key, cur_q);
            cnt_d   = CNT_W'(REPEAT_DELAY);
            rep_d   = evt_key;
            state_d = S_REPEAT;
          end
        end else if (state_q == S_REPEAT) begin
          if (!keys[rep_q]) begin
            state_d = S_IDLE;
          end else if (cnt_q <= CNT_W'(1)) begin
            // The step lands on the cycle the count reaches zero.
            cur_d = step_cursor(rep_q, cur_q);
            cnt_d = CNT_W'(REPEAT_PERIOD);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rep_q    <= KEY_UP;
      cur_q    <= '0;
      sw_q     <= '0;
      mom_up_q <= '0;
      mom_dn_q <= '0;
      act_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      cur_q    <= cur_d;
      sw_q     <= sw_d;
      mom_up_q <= mom_up_d;
      mom_dn_q <= mom_dn_d;
      act_q    <= act_d;
    end
  end

  assign bus.cursor_index_x = cur_q.x;
  assign bus.cursor_index_y = cur_q.y;
  assign bus.cursor_action  = act_q;
  assign bus.sw_state       = sw_q;
  assign bus.mom_up         = mom_up_q;
  assign bus.mom_down       = mom_dn_q;

endmodule

// File: tb/tb_front_panel_cursor_ctrl.sv
// Scoreboard bench for front_panel_cursor_ctrl: stimulus queues cycle-stamped
// expected outputs, a negedge monitor pops and compares them.
module tb_front_panel_cursor_ctrl;

  typedef struct packed {
    logic [3:0]  x;
    logic [4:0]  y;
    logic        act;
    logic [16:0] sw;
    logic [7:0]  mu;
    logic [7:0]  md;
  } obs_t;

  typedef struct {
    int    due;
    string name;
    obs_t  v;
  } exp_t;

  localparam logic [5:0] K_AU = 6'b000001;
  localparam logic [5:0] K_AD = 6'b000010;
  localparam logic [5:0] K_U  = 6'b000100;
  localparam logic [5:0] K_D  = 6'b001000;
  localparam logic [5:0] K_L  = 6'b010000;
  localparam logic [5:0] K_R  = 6'b100000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  obs_t e_;

  front_panel_cursor_ctrl_if bus();

  front_panel_cursor_ctrl #(
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (4),
    .HOLD_CYCLES   (8),
    .CNT_W         (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d: got x=%0d y=%0d act=%b sw=%h up=%h dn=%h, want x=%0d y=%0d act=%b sw=%h up=%h dn=%h",
               name, cyc, got.x, got.y, got.act, got.sw, got.mu, got.md,
               want.x, want.y, want.act, want.sw, want.mu, want.md);
    end
  endtask

  always @(negedge clk) begin
    obs_t got;
    exp_t e;
    got = '{x: bus.cursor_index_x, y: bus.cursor_index_y, act: bus.cursor_action,
            sw: bus.sw_state, mu: bus.mom_up, md: bus.mom_down};
    while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.due == cyc) begin
        check(e.name, got, e.v);
      end else begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.due, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int off, input string name);
    sb_q.push_back('{due: cyc + off, name: name, v: e_});
  endtask

  task automatic set_keys(input logic [5:0] k);
    bus.key_act_up   = k[0];
    bus.key_act_down = k[1];
    bus.key_up       = k[2];
    bus.key_down     = k[3];
    bus.key_left     = k[4];
    bus.key_right    = k[5];
  endtask

  // One-cycle key pulse followed by one idle cycle; e_ must already hold the
  // state expected on the cycle after the pulse.
  task automatic pulse(input logic [5:0] k, input string name);
    push_exp(1, name);
    set_keys(k);
    tick();
    set_keys(6'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    e_ = '0;
    set_keys(6'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    push_exp(0, "reset_state");
    tick();

    // Single steps right, then wraps in row 0.
    e_.x = 4'd1;  pulse(K_R, "right_1");
    e_.x = 4'd2;  pulse(K_R, "right_2");
    e_.x = 4'd3;  pulse(K_R, "right_3");
    e_.x = 4'd2;  pulse(K_L, "left_2");
    e_.x = 4'd1;  pulse(K_L, "left_1");
    e_.x = 4'd0;  pulse(K_L, "left_0");
    e_.x = 4'd15; pulse(K_L, "row0_wrap_left");
    e_.x = 4'd0;  pulse(K_R, "row0_wrap_right");
    e_.x = 4'd15; pulse(K_L, "left_15");
    e_.x = 4'd14; pulse(K_L, "left_14");
    e_.x = 4'd13; pulse(K_L, "left_13");
    e_.x = 4'd12; pulse(K_L, "left_12");

    // Row change with clamp, no-op down in row 1, row-1 wrap.
    e_.y = 5'd16; e_.x = 4'd8; pulse(K_D, "down_clamp");
    pulse(K_D, "down_noop_row1");
    e_.x = 4'd0; pulse(K_R, "row1_wrap_right");
    e_.x = 4'd1; pulse(K_R, "r1_right_1");
    e_.x = 4'd2; pulse(K_R, "r1_right_2");
    e_.x = 4'd3; pulse(K_R, "r1_right_3");
    e_.x = 4'd4; pulse(K_R, "r1_right_4");
    e_.x = 4'd5; pulse(K_R, "r1_right_5");

    // Auto-repeat: steps on held cycles 1, 11, 15, 19.
    e_.x = 4'd4; push_exp(1, "rep_first");  push_exp(10, "rep_wait_delay");
    e_.x = 4'd3; push_exp(11, "rep_second"); push_exp(14, "rep_wait_period");
    e_.x = 4'd2; push_exp(15, "rep_third");
    e_.x = 4'd1; push_exp(19, "rep_fourth"); push_exp(20, "rep_end");
    set_keys(K_L);
    repeat (20) tick();
    set_keys(6'b0);
    tick();
    tick();

    // Up keeps x; toggle switch 4 set and cleared.
    e_.y = 5'd0; pulse(K_U, "up_keep_x");
    e_.x = 4'd2; pulse(K_R, "r0_right_2");
    e_.x = 4'd3; pulse(K_R, "r0_right_3");
    e_.x = 4'd4; pulse(K_R, "r0_right_4");
    e_.sw[4] = 1'b1; e_.act = 1'b1; pulse(K_AU, "toggle4_set");
    e_.act = 1'b0; push_exp(0, "toggle4_act_one_cycle");
    e_.sw[4] = 1'b0; e_.act = 1'b1; pulse(K_AD, "toggle4_clear");
    e_.act = 1'b0; push_exp(0, "toggle4_clear_act_end");
    tick();

    // Momentary switch 20 (bit 3): hold ignores right presses and a key held on exit.
    e_.y = 5'd16; pulse(K_D, "down_to_L20");
    e_.md = 8'b0000_1000; e_.act = 1'b1; push_exp(1, "mom_down_pulse");
    e_.md = 8'b0; push_exp(2, "mom_down_one_cycle");
    push_exp(8, "hold_act_last");
    e_.act = 1'b0; push_exp(9, "hold_act_end");
    push_exp(12, "hold_keys_ignored");
    set_keys(K_AD); tick(); set_keys(6'b0); tick();
    set_keys(K_R);  tick(); set_keys(6'b0); tick();
    set_keys(K_R);  tick(); set_keys(6'b0); tick();
    set_keys(K_R);  repeat (5) tick();
    set_keys(6'b0); tick();
    tick();

    e_.mu = 8'b0000_1000; e_.act = 1'b1; push_exp(1, "mom_up_pulse");
    e_.mu = 8'b0; push_exp(2, "mom_up_one_cycle");
    e_.act = 1'b0; push_exp(9, "mom_up_hold_end");
    set_keys(K_AU); tick(); set_keys(6'b0);
    repeat (10) tick();

    // Action beats a simultaneous direction key.
    e_.y = 5'd0; pulse(K_U, "up_to_row0");
    e_.x = 4'd3; pulse(K_L, "r0_left_3");
    e_.x = 4'd2; pulse(K_L, "r0_left_2");
    e_.sw[2] = 1'b1; e_.act = 1'b1; pulse(K_AU | K_L, "act_beats_left");
    e_.act = 1'b0; push_exp(0, "act_beats_left_after");
    tick();

    // Reset during a hold clears everything, including toggle states.
    e_.y = 5'd16; pulse(K_D, "down_to_L18");
    e_.mu = 8'b0000_0010; e_.act = 1'b1; push_exp(1, "mom18_pulse");
    e_.mu = 8'b0; push_exp(3, "mom18_holding");
    e_ = '0; push_exp(4, "reset_in_hold"); push_exp(5, "reset_in_hold_stays");
    set_keys(K_AU); tick(); set_keys(6'b0);
    tick();
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    tick();
    e_.x = 4'd1; pulse(K_R, "idle_after_reset");

    repeat (3) tick();
    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never compared", e.name, e.due);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
